// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants for the 20-bit LFSR and its period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR20_WIDTH  = 20;
    localparam int LFSR20_PERIOD = 1048575;

    // Monitor FSM encoding, shared with lfsr_20bit benches
    localparam logic [0:0] ST_SYNC    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_stuck_det.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_stuck_det
// Description : Flags an LFSR stream that repeats a value or hits all-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stuck_det
    import lfsr_pkg::*;
#(
    parameter int WIDTH       = LFSR20_WIDTH,
    parameter int STUCK_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_lfsr_q,
    output logic             o_stuck
);

    localparam int                  c_same_w    = (STUCK_LIMIT > 2) ? $clog2(STUCK_LIMIT) : 1;
    localparam logic [c_same_w-1:0] c_same_max  = c_same_w'(STUCK_LIMIT - 1);
    localparam logic [c_same_w-1:0] c_same_trip = c_same_w'(STUCK_LIMIT - 2);

    logic [WIDTH-1:0]    r_q_prev;
    logic                r_q_vld;
    logic [c_same_w-1:0] r_same_cnt;
    logic                w_match;

    assign w_match = r_q_vld && (i_lfsr_q == r_q_prev);

    // Trips on the edge where the run of equal samples reaches STUCK_LIMIT
    assign o_stuck = (w_match && (r_same_cnt == c_same_trip)) ||
                     (r_q_vld && (i_lfsr_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_prev   <= '0;
            r_q_vld    <= 1'b0;
            r_same_cnt <= '0;
        end else begin
            r_q_prev <= i_lfsr_q;
            if (i_clr) begin
                r_q_vld    <= 1'b0;
                r_same_cnt <= '0;
            end else begin
                r_q_vld <= 1'b1;
                if (!w_match) begin
                    r_same_cnt <= '0;
                end else if (r_same_cnt != c_same_max) begin
                    r_same_cnt <= r_same_cnt + 1'b1;
                end
            end
        end
    end

endmodule : lfsr_stuck_det
`default_nettype wire

// File: rtl/lfsr_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_period_monitor
// Description : Checks max_tick spacing and stream health of an LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int WIDTH       = LFSR20_WIDTH,
    parameter int PERIOD      = LFSR20_PERIOD,
    parameter int STUCK_LIMIT = 4,
    parameter int CNT_W       = 16,
    localparam int CYC_W      = $clog2(PERIOD + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lfsr_q,
    input  logic             lfsr_tick,
    input  logic             clr,
    output logic             period_ok,
    output logic             period_err,
    output logic             stuck_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CYC_W-1:0] last_period,
    output logic             locked
);

    localparam logic [CYC_W-1:0] c_period  = CYC_W'(PERIOD);
    localparam logic [CYC_W-1:0] c_timeout = CYC_W'(PERIOD + 1);

    logic [0:0]       r_state;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic             r_period_ok;
    logic             r_period_err;
    logic             r_stuck_err;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CYC_W-1:0] r_last_period;
    logic             w_stuck;

    lfsr_stuck_det #(
        .WIDTH       (WIDTH),
        .STUCK_LIMIT (STUCK_LIMIT)
    ) u_stuck_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (clr),
        .i_lfsr_q (lfsr_q),
        .o_stuck  (w_stuck)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SYNC;
            r_cyc_cnt     <= '0;
            r_period_ok   <= 1'b0;
            r_period_err  <= 1'b0;
            r_stuck_err   <= 1'b0;
            r_good_cnt    <= '0;
            r_last_period <= '0;
        end else if (clr) begin
            // Clear takes priority over any tick on the same edge
            r_state       <= ST_SYNC;
            r_cyc_cnt     <= '0;
            r_period_ok   <= 1'b0;
            r_period_err  <= 1'b0;
            r_stuck_err   <= 1'b0;
            r_good_cnt    <= '0;
            r_last_period <= '0;
        end else begin
            r_period_ok <= 1'b0;
            if (w_stuck) begin
                r_stuck_err <= 1'b1;
            end
            case (r_state)
                ST_SYNC: begin
                    if (lfsr_tick) begin
                        r_state   <= ST_MEASURE;
                        r_cyc_cnt <= CYC_W'(1);
                    end
                end
                default: begin
                    if (lfsr_tick) begin
                        r_last_period <= r_cyc_cnt;
                        r_cyc_cnt     <= CYC_W'(1);
                        if (r_cyc_cnt == c_period) begin
                            r_period_ok <= 1'b1;
                            if (r_good_cnt != '1) begin
                                r_good_cnt <= r_good_cnt + 1'b1;
                            end
                        end else begin
                            r_period_err <= 1'b1;
                        end
                    end else if (r_cyc_cnt == c_timeout) begin
                        // Missing tick: drop lock so the counter never wraps
                        r_period_err  <= 1'b1;
                        r_last_period <= c_timeout;
                        r_cyc_cnt     <= '0;
                        r_state       <= ST_SYNC;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign period_ok   = r_period_ok;
    assign period_err  = r_period_err;
    assign stuck_err   = r_stuck_err;
    assign good_cnt    = r_good_cnt;
    assign last_period = r_last_period;
    assign locked      = (r_state == ST_MEASURE);

endmodule : lfsr_period_monitor
`default_nettype wire

// File: tb/tb_lfsr_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_period_monitor
// Description : Directed self-checking bench for lfsr_period_monitor (PERIOD=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_period_monitor;

    localparam int c_width  = 4;
    localparam int c_period = 15;
    localparam int c_cnt_w  = 16;
    localparam int c_cyc_w  = $clog2(c_period + 2);

    logic               clk;
    logic               rst_n;
    logic [c_width-1:0] lfsr_q;
    logic               lfsr_tick;
    logic               clr;
    logic               period_ok;
    logic               period_err;
    logic               stuck_err;
    logic [c_cnt_w-1:0] good_cnt;
    logic [c_cyc_w-1:0] last_period;
    logic               locked;

    int checks = 0;
    int errors = 0;
    bit q_auto = 1'b0;

    lfsr_period_monitor #(
        .WIDTH       (c_width),
        .PERIOD      (c_period),
        .STUCK_LIMIT (4),
        .CNT_W       (c_cnt_w)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lfsr_q      (lfsr_q),
        .lfsr_tick   (lfsr_tick),
        .clr         (clr),
        .period_ok   (period_ok),
        .period_err  (period_err),
        .stuck_err   (stuck_err),
        .good_cnt    (good_cnt),
        .last_period (last_period),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge; in auto mode lfsr_q walks 1..15 so it never repeats or hits 0
    task automatic step(input logic tick);
        lfsr_tick = tick;
        if (q_auto) lfsr_q = c_width'((lfsr_q % 15) + 1);
        @(posedge clk);
        #1;
        lfsr_tick = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; lfsr_tick = 1'b0; lfsr_q = 4'h1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ok",     period_ok,   0);
        check("rst_err",    period_err,  0);
        check("rst_stuck",  stuck_err,   0);
        check("rst_good",   good_cnt,    0);
        check("rst_last",   last_period, 0);
        check("rst_locked", locked,      0);
        rst_n = 1'b1;
        q_auto = 1'b1;

        // Ticks spaced 15, 15, 14
        step(1'b1);
        check("lock_first", locked, 1);
        gap(14); step(1'b1);
        check("p1_ok",   period_ok,   1);
        check("p1_good", good_cnt,    1);
        check("p1_last", last_period, 15);
        step(1'b0);
        check("p1_pulse_end", period_ok, 0);
        gap(13); step(1'b1);
        check("p2_ok",   period_ok, 1);
        check("p2_good", good_cnt,  2);
        gap(13); step(1'b1);
        check("p3_err",    period_err,  1);
        check("p3_last",   last_period, 14);
        check("p3_ok",     period_ok,   0);
        check("p3_good",   good_cnt,    2);
        check("p3_locked", locked,      1);
        check("p3_stuck",  stuck_err,   0);

        // Timeout after 16 tick-free clocks
        clr = 1'b1; step(1'b0); clr = 1'b0;
        check("clr_err",    period_err, 0);
        check("clr_good",   good_cnt,   0);
        check("clr_locked", locked,     0);
        step(1'b1);
        gap(15);
        check("to_pre_err",    period_err, 0);
        check("to_pre_locked", locked,     1);
        step(1'b0);
        check("to_err",    period_err,  1);
        check("to_last",   last_period, 16);
        check("to_locked", locked,      0);
        step(1'b1);
        check("relock_locked", locked,    1);
        check("relock_ok",     period_ok, 0);

        // Stuck detection: 3 equal edges pass, 4th trips
        q_auto = 1'b0;
        lfsr_q = 4'h6; step(1'b0);
        lfsr_q = 4'h5; gap(3);
        check("stuck_3", stuck_err, 0);
        step(1'b0);
        check("stuck_4", stuck_err, 1);
        clr = 1'b1; lfsr_q = 4'h7; step(1'b0); clr = 1'b0;
        check("stuck_clr", stuck_err, 0);
        lfsr_q = 4'h3; step(1'b0);
        check("zero_pre", stuck_err, 0);
        lfsr_q = 4'h0; step(1'b0);
        check("zero_hit", stuck_err, 1);

        // clr wins over a simultaneous tick
        q_auto = 1'b1;
        step(1'b1); gap(14); step(1'b1);
        check("c5_good", good_cnt, 1);
        gap(5); step(1'b1);
        check("c5_err", period_err, 1);
        clr = 1'b1; step(1'b1); clr = 1'b0;
        check("cw_ok",     period_ok,   0);
        check("cw_err",    period_err,  0);
        check("cw_stuck",  stuck_err,   0);
        check("cw_good",   good_cnt,    0);
        check("cw_last",   last_period, 0);
        check("cw_locked", locked,      0);
        step(1'b1);
        check("cw_relock", locked,    1);
        check("cw_nopulse", period_ok, 0);

        // Asynchronous reset mid-MEASURE
        gap(14); step(1'b1);
        check("ar_pre_good", good_cnt, 1);
        gap(3);
        #2 rst_n = 1'b0;
        #1;
        check("ar_locked", locked,      0);
        check("ar_good",   good_cnt,    0);
        check("ar_last",   last_period, 0);
        check("ar_ok",     period_ok,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lfsr_period_monitor
`default_nettype wire
